// File: rtl/nand4_sweep_ctrl.sv
// Purpose: sequences all 16 input vectors into a 4-input NAND under test and self-checks its output.
// Latency: start accepted at edge N -> DONE entered at edge N+16*HOLD_CYCLES, done pulses the cycle after.
// Backpressure: none; start is only honoured in IDLE, and is dropped (not queued) while sweeping.
//
// Ports:
//   clk, rst_n        clock (rising edge) and asynchronous active-low reset
//   start             sweep request, accepted only in IDLE
//   dut_y             output of the gate under test, assumed synchronous to clk
//   a, b, c, d        gate inputs, registered copy of vec_idx (a = bit 3, d = bit 0)
//   vec_idx           current vector {a,b,c,d}
//   busy, done        sweep in progress / one-cycle end-of-sweep pulse
//   pass              last sweep saw zero mismatches; held until the next accepted start
//   err_cnt           mismatch count 0..16 (5 bits so 16 does not wrap)
//   first_err_valid   at least one mismatch seen in this sweep
//   first_err_vec     vector at which the first mismatch was seen
module nand4_sweep_ctrl #(
    parameter int HOLD_CYCLES   = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       dut_y,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic [3:0] vec_idx,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_cnt,
    output logic       first_err_valid,
    output logic [3:0] first_err_vec
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] SAMPLE_AT = 8'(SETTLE_CYCLES);

    logic [1:0] state;
    logic [3:0] vec;
    logic [7:0] hold_cnt;

    // Decoded events for the current cycle.
    logic       in_run;
    logic       sample_edge;
    logic       vec_end;
    logic       last_vec;
    logic       expected_y;
    logic       mismatch;
    logic [4:0] err_cnt_upd;

    always_comb begin
        in_run      = (state == ST_RUN);
        sample_edge = in_run && (hold_cnt == SAMPLE_AT);
        vec_end     = in_run && (hold_cnt == HOLD_LAST);
        last_vec    = (vec == 4'hF);
        expected_y  = ~(&vec);
        mismatch    = sample_edge && (dut_y != expected_y);
        // The sample edge may coincide with the end-of-vector edge when
        // SETTLE_CYCLES == HOLD_CYCLES-1, so pass is judged on the updated count.
        err_cnt_upd = err_cnt + 5'(mismatch);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            vec             <= 4'd0;
            hold_cnt        <= 8'd0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_cnt         <= 5'd0;
            first_err_valid <= 1'b0;
            first_err_vec   <= 4'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // vec keeps its last driven value while idle.
                    done <= 1'b0;
                    if (start) begin
                        state           <= ST_RUN;
                        vec             <= 4'd0;
                        hold_cnt        <= 8'd0;
                        busy            <= 1'b1;
                        pass            <= 1'b0;
                        err_cnt         <= 5'd0;
                        first_err_valid <= 1'b0;
                        first_err_vec   <= 4'd0;
                    end
                end

                ST_RUN: begin
                    if (mismatch) begin
                        err_cnt <= err_cnt_upd;
                        if (!first_err_valid) begin
                            first_err_valid <= 1'b1;
                            first_err_vec   <= vec;
                        end
                    end

                    if (vec_end) begin
                        if (last_vec) begin
                            // Vector 1111 stays on the gate inputs after the sweep.
                            state    <= ST_DONE;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            pass     <= (err_cnt_upd == 5'd0);
                            hold_cnt <= 8'd0;
                        end else begin
                            vec      <= vec + 4'd1;
                            hold_cnt <= 8'd0;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end

                ST_DONE: begin
                    // One-cycle pulse; a start seen here is deliberately dropped.
                    state <= ST_IDLE;
                    done  <= 1'b0;
                end

                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    assign vec_idx = vec;
    assign a       = vec[3];
    assign b       = vec[2];
    assign c       = vec[1];
    assign d       = vec[0];

endmodule

// File: tb/tb_nand4_sweep_ctrl.sv
module tb_nand4_sweep_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       dut_y;
    logic       a, b, c, d;
    logic [3:0] vec_idx;
    logic       busy;
    logic       done;
    logic       pass;
    logic [4:0] err_cnt;
    logic       first_err_valid;
    logic [3:0] first_err_vec;

    int checks   = 0;
    int failures = 0;

    // Gate model: 0 ideal, 1 stuck-at-1, 2 inverted, 3 ideal but wrong on phases 0 and 3.
    int         mode = 0;
    logic [1:0] ph;

    nand4_sweep_ctrl #(.HOLD_CYCLES(4), .SETTLE_CYCLES(1)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .dut_y           (dut_y),
        .a               (a),
        .b               (b),
        .c               (c),
        .d               (d),
        .vec_idx         (vec_idx),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .err_cnt         (err_cnt),
        .first_err_valid (first_err_valid),
        .first_err_vec   (first_err_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Phase within a 4-cycle vector slot, aligned to the accepted start edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                       ph <= 2'd0;
        else if (start && !busy && !done) ph <= 2'd0;
        else                              ph <= ph + 2'd1;
    end

    always_comb begin
        case (mode)
            1:       dut_y = 1'b1;
            2:       dut_y = a & b & c & d;
            3:       dut_y = (ph == 2'd0 || ph == 2'd3) ? (a & b & c & d) : ~(a & b & c & d);
            default: dut_y = ~(a & b & c & d);
        endcase
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [21:0] all_outs();
        return {a, b, c, d, vec_idx, busy, done, pass, err_cnt, first_err_valid, first_err_vec};
    endfunction

    // Pulses (or holds) start, then follows the sweep to its done pulse,
    // checking the vector sequence and the 64-cycle length.
    task automatic run_sweep(input bit hold_start, input bit poke_start);
        int  k;
        bit  vec_ok;
        bit  busy_ok;
        @(negedge clk) start = 1'b1;
        @(negedge clk) if (!hold_start) start = 1'b0;
        check_eq("start_busy", busy, 1);
        check_eq("start_vec", vec_idx, 0);
        check_eq("start_err", err_cnt, 0);
        check_eq("start_pass", pass, 0);
        k       = 0;
        vec_ok  = 1'b1;
        busy_ok = 1'b1;
        while (!done && k < 80) begin
            if ({a, b, c, d} != 4'(k >> 2) || vec_idx != 4'(k >> 2)) vec_ok = 1'b0;
            if (!busy) busy_ok = 1'b0;
            @(negedge clk);
            k++;
            if (poke_start) start = (k == 21);
        end
        start = hold_start;
        check_eq("vec_sequence", vec_ok, 1);
        check_eq("busy_whole_sweep", busy_ok, 1);
        check_eq("sweep_len", k, 64);
        check_eq("done_busy_low", busy, 0);
        check_eq("done_vec_1111", {a, b, c, d}, 4'hF);
    endtask

    initial begin
        int k;
        int done_seen;
        rst_n = 1'b0;
        start = 1'b1;

        // Reset held with start high.
        repeat (3) begin
            @(negedge clk);
            check_eq("reset_outputs", all_outs(), 0);
        end
        @(posedge clk);
        #2;
        start = 1'b0;
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check_eq("post_release_outputs", all_outs(), 0);
        end

        // Ideal gate.
        mode = 0;
        run_sweep(1'b0, 1'b0);
        check_eq("ideal_pass", pass, 1);
        check_eq("ideal_err", err_cnt, 0);
        check_eq("ideal_fev", first_err_valid, 0);
        @(negedge clk);
        check_eq("done_one_cycle", done, 0);
        check_eq("pass_held", pass, 1);
        check_eq("idle_keeps_1111", {a, b, c, d}, 4'hF);

        // Stuck-at-1: only 1111 mismatches.
        mode = 1;
        run_sweep(1'b0, 1'b0);
        check_eq("stuck1_err", err_cnt, 1);
        check_eq("stuck1_fev", first_err_valid, 1);
        check_eq("stuck1_vec", first_err_vec, 4'hF);
        check_eq("stuck1_pass", pass, 0);

        // Inverted gate: every vector mismatches, count reaches 16 without wrap.
        mode = 2;
        run_sweep(1'b0, 1'b0);
        check_eq("inv_err", err_cnt, 16);
        check_eq("inv_fev", first_err_valid, 1);
        check_eq("inv_vec", first_err_vec, 0);
        check_eq("inv_pass", pass, 0);

        // Glitches off the sample edge plus a stray start in vector 5.
        mode = 3;
        run_sweep(1'b0, 1'b1);
        check_eq("glitch_err", err_cnt, 0);
        check_eq("glitch_pass", pass, 1);
        done_seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (done || busy) done_seen++;
        end
        check_eq("no_restart", done_seen, 0);

        // Reset in the middle of a sweep (inverted gate, vector 0111).
        mode = 2;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        k = 0;
        while (vec_idx != 4'd7 && k < 80) begin
            @(negedge clk);
            k++;
        end
        check_eq("midrun_reach_7", k, 28);
        check_eq("midrun_err_before", err_cnt, 7);
        #2 rst_n = 1'b0;
        #1;
        check_eq("midrun_abort_outs", all_outs(), 0);
        #1 rst_n = 1'b1;
        mode = 0;
        run_sweep(1'b0, 1'b0);
        check_eq("after_abort_pass", pass, 1);
        check_eq("after_abort_err", err_cnt, 0);

        // start held high: retrigger one cycle after DONE, from IDLE.
        run_sweep(1'b1, 1'b0);
        @(negedge clk);
        check_eq("held_idle_busy", busy, 0);
        @(negedge clk);
        check_eq("held_retrigger_busy", busy, 1);
        check_eq("held_retrigger_vec", vec_idx, 0);
        start = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nand4_sweep_ctrl.md
Name: nand4_sweep_ctrl

Overview:
- Sequencer and self-checker for a 4-input NAND gate under test.
- On a start pulse it drives all 16 input combinations in binary order, with a as MSB and d as LSB, holding each vector for HOLD_CYCLES clocks.
- Samples the gate output once per vector after SETTLE_CYCLES and compares it against the ideal NAND of the driven vector.
- Reports mismatch count, first failing vector and pass/fail, replacing free-running toggle stimulus with a deterministic, self-checking sweep.

Parameters:
- HOLD_CYCLES, 4, clocks each vector is held on a..d; legal range 2..255.
- SETTLE_CYCLES, 1, clocks after vector change before dut_y is sampled; legal range 1..HOLD_CYCLES-1.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  sweep request; accepted only in IDLE
- dut_y  input  1  output of the NAND gate under test
- a  output  1  gate input, vector bit 3
- b  output  1  gate input, vector bit 2
- c  output  1  gate input, vector bit 1
- d  output  1  gate input, vector bit 0
- vec_idx  output  4  current vector {a,b,c,d}
- busy  output  1  high while sweeping
- done  output  1  one-cycle pulse at sweep end
- pass  output  1  high when the last sweep had zero errors; held until the next accepted start
- err_cnt  output  5  mismatch count, 0..16
- first_err_valid  output  1  at least one mismatch in this sweep
- first_err_vec  output  4  vector of the first mismatch

Behaviour:
- Reset is asynchronous on rst_n low and returns the block to IDLE.
  - All outputs are 0, including a..d, vec_idx, busy, done, pass, err_cnt, first_err_valid and first_err_vec.
  - Internal hold counter is cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - a..d hold their last driven value; after reset this is 0000.
  - When start is high at edge N, the next state is RUN.
  - At edge N: vec=0000, hold_cnt=0, busy=1, err_cnt=0, first_err_valid=0, first_err_vec=0, pass=0.
- RUN:
  - {a,b,c,d} = vec_idx, driven from registers with no combinational path from inputs.
  - hold_cnt increments every cycle, from 0 to HOLD_CYCLES-1.
  - Sample edge is when hold_cnt==SETTLE_CYCLES. Expected value is ~(a&b&c&d).
    - If dut_y differs from expected, err_cnt increments.
    - If first_err_valid==0, first_err_vec=vec_idx and first_err_valid=1.
  - dut_y is ignored on every other cycle; glitches outside the sample edge are never counted.
  - End-of-vector edge is when hold_cnt==HOLD_CYCLES-1.
    - If vec_idx != 1111: vec_idx increments and hold_cnt=0.
    - If vec_idx == 1111: next state is DONE and a..d keep 1111.
- DONE:
  - Lasts exactly one cycle, with done=1 and busy=0.
  - pass = (err_cnt==0), registered on entry to DONE.
  - Next state is IDLE.
- Timing:
  - With start accepted at edge N, the DONE entry edge is N+16*HOLD_CYCLES.
  - done is high for the following cycle; busy is high from edge N to DONE entry.
- Counter width: err_cnt is 5 bits, and its maximum of 16 fits without wrap.
- start handling:
  - start in RUN or DONE is ignored and is not queued.
  - start held high continuously retriggers one cycle after DONE, from IDLE.
- Reset mid-sweep: immediate abort to IDLE with all outputs 0 and no done pulse. The next sweep restarts from 0000 with cleared results.
- dut_y is assumed synchronous to clk; no input synchronizer is required.

Test Plan:
- Reset: hold rst_n=0 with start=1 for 3 cycles -> all outputs 0, busy stays 0. Release rst_n asynchronously mid-cycle -> outputs still 0 until the next rising edge with start high.
- Ideal gate (dut_y = ~(a&b&c&d)), HOLD=4, SETTLE=1, start pulse at edge 10:
  - a..d step 0000, 0001, … 1111, changing every 4 cycles.
  - busy=1 for edges 10..73; done pulse after edge 74.
  - Result: pass=1, err_cnt=0, first_err_valid=0.
- Stuck-at-1 gate (dut_y=1) -> only vector 1111 mismatches: err_cnt=1, first_err_vec=1111, first_err_valid=1, pass=0.
- Inverted gate (dut_y = a&b&c&d) -> err_cnt=16 (5'b10000), first_err_vec=0000, pass=0, with no counter wrap.
- Glitch plus ignored start: ideal gate with dut_y forced to the wrong value only when hold_cnt=0 or 3, and a second start pulse during vector 5 -> err_cnt=0, pass=1, a single done pulse, and no restart.
- Reset mid-run: drop rst_n while vec_idx=0111 -> a..d=0000, busy=0, err_cnt=0 immediately. A new start gives a full 64-cycle sweep from 0000 with correct results.
